// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_conditioner
// Description : Synchronizes and glitch-filters raw I2C SCL/SDA pads, reports
//               SCL edges, START/STOP conditions, bus-busy and stuck-SCL timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_out,
  output logic sda_out,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam int                C_TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST   = C_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_TO_W-1:0] C_TO_PRE    = C_TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]        C_FILT_LAST = 4'(FILTER_LEN - 1);

  // Index 1 carries SCL, index 0 carries SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {scl_in, sda_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= 2'b11;
        r_cnt  <= 4'd0;
        r_filt <= 1'b1;
      end else begin
        r_sync <= {r_sync[0], w_raw[gi]};
        if (r_sync[1] == r_filt) begin
          r_cnt <= 4'd0;
        end else if (r_cnt == C_FILT_LAST) begin
          r_filt <= r_sync[1];
          r_cnt  <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end

    assign w_filt[gi] = r_filt;
  end

  // Output stage compares the newly filtered level against the level currently
  // presented, so every pulse lines up with the cycle the new level appears.
  logic w_sclNext;
  logic w_sdaNext;
  logic w_start;
  logic w_stop;

  assign w_sclNext = w_filt[1];
  assign w_sdaNext = w_filt[0];
  assign w_start   = scl_out & w_sclNext &  sda_out & ~w_sdaNext;
  assign w_stop    = scl_out & w_sclNext & ~sda_out &  w_sdaNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_out   <= 1'b1;
      sda_out   <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_out   <= w_sclNext;
      sda_out   <= w_sdaNext;
      scl_rise  <= ~scl_out &  w_sclNext;
      scl_fall  <=  scl_out & ~w_sclNext;
      start_det <= w_start;
      stop_det  <= w_stop;
    end
  end

  // Stuck-SCL watchdog: the pulse is registered so it coincides with the
  // cycle in which the counter holds its final value.
  logic [C_TO_W-1:0] r_toCnt;
  logic              w_toClr;
  logic              w_toInc;

  assign w_toClr = ~bus_busy | scl_rise | scl_fall | stop_det;
  assign w_toInc = ~w_toClr & ~scl_out & (r_toCnt != C_TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_toCnt     <= '0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= w_toInc & (r_toCnt == C_TO_PRE);
      if (w_toClr || r_toCnt == C_TO_LAST) begin
        r_toCnt <= '0;
      end else if (w_toInc) begin
        r_toCnt <= r_toCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_busy <= 1'b0;
    end else if (start_det) begin
      bus_busy <= 1'b1;
    end else if (stop_det || bus_timeout) begin
      bus_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bus_conditioner
// Description : Directed vector table plus hand sequences for the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_conditioner;

  logic clk;
  logic rst;
  logic scl_in;
  logic sda_in;
  logic scl_out;
  logic sda_out;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_busy;
  logic bus_timeout;

  i2c_bus_conditioner #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_out    (scl_out),
    .sda_out    (sda_out),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector order: {scl_out, sda_out, rise, fall, start, stop, busy, timeout}
  typedef struct {
    logic       rst;
    logic       scl;
    logic       sda;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  int nCompared   = 0;
  int nMismatched = 0;
  int nRise, nFall, nStart, nStop, nTimeout, nSclLow;

  task automatic addRows(input int n, input logic r, input logic s, input logic d,
                         input logic [7:0] e);
    vec_t v;
    v.rst = r; v.scl = s; v.sda = d; v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clrCounts();
    nRise = 0; nFall = 0; nStart = 0; nStop = 0; nTimeout = 0; nSclLow = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (scl_rise)    nRise++;
    if (scl_fall)    nFall++;
    if (start_det)   nStart++;
    if (stop_det)    nStop++;
    if (bus_timeout) nTimeout++;
    if (!scl_out)    nSclLow++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic doReset();
    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(3);
    clrCounts();
  endtask

  task automatic doStart();
    scl_in = 1'b1; sda_in = 1'b1;
    ticks(10);
    sda_in = 1'b0;
    ticks(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] bits;
    int         n;
    logic       seen;

    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1;

    // START, SCL fall, 3- and 4-cycle high glitches on SCL, SCL rise, STOP.
    addRows(2, 1, 1, 1, 8'b1100_0000);
    addRows(6, 0, 1, 0, 8'b1100_0000);
    addRows(1, 0, 1, 0, 8'b1000_1000);
    addRows(1, 0, 1, 0, 8'b1000_0010);
    addRows(6, 0, 0, 0, 8'b1000_0010);
    addRows(1, 0, 0, 0, 8'b0001_0010);
    addRows(1, 0, 0, 0, 8'b0000_0010);
    addRows(3, 0, 1, 0, 8'b0000_0010);
    addRows(6, 0, 0, 0, 8'b0000_0010);
    addRows(4, 0, 1, 0, 8'b0000_0010);
    addRows(2, 0, 0, 0, 8'b0000_0010);
    addRows(1, 0, 0, 0, 8'b1010_0010);
    addRows(3, 0, 0, 0, 8'b1000_0010);
    addRows(1, 0, 0, 0, 8'b0001_0010);
    addRows(6, 0, 1, 0, 8'b0000_0010);
    addRows(1, 0, 1, 0, 8'b1010_0010);
    addRows(1, 0, 1, 0, 8'b1000_0010);
    addRows(6, 0, 1, 1, 8'b1000_0010);
    addRows(1, 0, 1, 1, 8'b1100_0110);
    addRows(3, 0, 1, 1, 8'b1100_0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; scl_in = vecs[i].scl; sda_in = vecs[i].sda;
      tick();
      check($sformatf("vec[%0d]", i),
            {24'd0, scl_out, sda_out, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout},
            {24'd0, vecs[i].exp});
    end

    // Low glitches on idle SCL: 3 cycles rejected, 4 cycles passed through.
    doReset();
    scl_in = 1'b0; ticks(3);
    scl_in = 1'b1; ticks(20);
    check("glitch3_fall", nFall, 0);
    check("glitch3_low", nSclLow, 0);
    clrCounts();
    scl_in = 1'b0; ticks(4);
    scl_in = 1'b1; ticks(20);
    check("glitch4_fall", nFall, 1);
    check("glitch4_rise", nRise, 1);
    check("glitch4_low", nSclLow, 4);
    check("glitch4_start", nStart, 0);

    // Byte 0xB2 plus ACK, then STOP.
    doReset();
    doStart();
    bits = 9'b1011_0010_0;
    for (int i = 8; i >= 0; i--) begin
      scl_in = 1'b0; ticks(3);
      sda_in = bits[i]; ticks(8);
      scl_in = 1'b1; ticks(10);
    end
    sda_in = 1'b1; ticks(12);
    check("byte_rise", nRise, 9);
    check("byte_fall", nFall, 9);
    check("byte_start", nStart, 1);
    check("byte_stop", nStop, 1);
    check("byte_timeout", nTimeout, 0);
    check("byte_busy_end", bus_busy, 0);

    // SCL stuck low after START.
    doReset();
    doStart();
    check("to_busy_pre", bus_busy, 1);
    scl_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = scl_fall;
    end
    check("to_fall_seen", seen, 1);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      n++;
      seen = bus_timeout;
    end
    check("to_latency", n, 100);
    check("to_busy_at_pulse", bus_busy, 1);
    tick();
    check("to_pulse_width", bus_timeout, 0);
    check("to_busy_cleared", bus_busy, 0);
    clrCounts();
    ticks(250);
    check("to_no_repeat", nTimeout, 0);

    // Both lines fall together from idle: SCL edge only.
    doReset();
    scl_in = 1'b0; sda_in = 1'b0;
    ticks(20);
    check("simul_fall", nFall, 1);
    check("simul_start", nStart, 0);
    check("simul_lines", {scl_out, sda_out}, 2'b00);
    check("simul_busy", bus_busy, 0);

    // Reset pulse mid-byte with both raw lines held low.
    doReset();
    doStart();
    scl_in = 1'b0; ticks(12);
    check("rst_busy_before", bus_busy, 1);
    rst = 1'b1;
    tick();
    check("rst_outputs",
          {scl_out, sda_out, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout},
          8'b1100_0000);
    rst = 1'b0;
    clrCounts();
    tick();
    check("rst_first_clock", {scl_out, sda_out, bus_busy}, 3'b110);
    ticks(5);
    check("rst_still_high", {scl_out, sda_out}, 2'b11);
    tick();
    check("rst_fall_edge", {scl_out, sda_out, scl_fall, start_det}, 4'b0010);
    ticks(10);
    check("rst_no_start", nStart + nStop, 0);
    check("rst_busy_after", bus_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
